// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned ENTRY_W     = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Parameterised single-clock FIFO with synchronous clear; head is read straight
// from the storage registers so consumers see no path from the write side.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             full;
   logic             empty;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= push_data;
   end

   assign head_data = mem[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with credit-based request throttling, in-order
// response tagging via a PC side FIFO, and redirect flush with response discard.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req_valid,
   output logic [31:0]              imem_req_addr,
   input  logic                     imem_req_ready,
   input  logic                     imem_rsp_valid,
   input  logic [31:0]              imem_rsp_data,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_reg, state_next;
   logic [31:0]   fetch_pc_reg;
   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] discard_cnt_reg, discard_cnt_next;
   logic [CW:0]   in_use;
   logic          credit_ok;
   logic          req_fire;
   logic          rsp_counted;
   logic          rsp_keep;
   logic [31:0]   pc_head;
   logic [CW-1:0] pc_count;
   logic [CW-1:0] data_count;
   logic [ENTRY_W-1:0] head_bits;
   fetch_entry_t  head_entry;
   fetch_entry_t  push_entry;

   // Slots already promised to in-flight requests count against capacity, so a
   // returning response can always be buffered.
   assign in_use    = {1'b0, data_count} + {1'b0, outstanding_reg};
   assign credit_ok = (in_use < (CW+1)'(DEPTH));

   assign imem_req_valid = (state_reg == FETCH) & credit_ok & ~redirect_valid & ~rst;
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A response with nothing tracked (stale traffic after reset) is ignored.
   assign rsp_counted = imem_rsp_valid & (outstanding_reg != '0);
   assign rsp_keep    = rsp_counted & (state_reg == FETCH) & ~redirect_valid & (pc_count != '0);

   always_comb begin
      outstanding_next = outstanding_reg;
      case ({req_fire, rsp_counted})
         2'b10:   outstanding_next = outstanding_reg + 1'b1;
         2'b01:   outstanding_next = outstanding_reg - 1'b1;
         default: outstanding_next = outstanding_reg;
      endcase
   end

   always_comb begin
      state_next       = state_reg;
      discard_cnt_next = discard_cnt_reg;
      if (redirect_valid) begin
         // Every response still owed after this cycle belongs to the old path.
         discard_cnt_next = outstanding_next;
         state_next       = (outstanding_next == '0) ? FETCH : DRAIN;
      end else if (state_reg == DRAIN && rsp_counted) begin
         discard_cnt_next = discard_cnt_reg - 1'b1;
         if (discard_cnt_reg == CW'(1)) state_next = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= FETCH;
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         discard_cnt_reg <= '0;
      end else begin
         state_reg       <= state_next;
         outstanding_reg <= outstanding_next;
         discard_cnt_reg <= discard_cnt_next;
         if (redirect_valid)
            fetch_pc_reg <= redirect_pc & ~32'(INSTR_BYTES - 1);
         else if (req_fire)
            fetch_pc_reg <= fetch_pc_reg + 32'(INSTR_BYTES);
      end
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_pc_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (redirect_valid),
      .push      (req_fire),
      .push_data (fetch_pc_reg),
      .pop       (rsp_keep),
      .head_data (pc_head),
      .count     (pc_count)
   );

   assign push_entry.pc    = pc_head;
   assign push_entry.instr = imem_rsp_data;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_data_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (redirect_valid),
      .push      (rsp_keep),
      .push_data (push_entry),
      .pop       (out_valid & out_ready),
      .head_data (head_bits),
      .count     (data_count)
   );

   assign head_entry = head_bits;
   assign out_valid  = (data_count != '0);
   assign out_pc     = head_entry.pc;
   assign out_instr  = head_entry.instr;
   assign occupancy  = data_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: per-cycle vector table plus redirect,
// reset and randomised-memory sequences against a behavioural memory model.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready = 1'b0;
   logic [2:0]  occupancy;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ready      (out_ready),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      bit          rst;
      bit          req_ready;
      bit          out_ready;
      bit          chk;
      bit          e_req_valid;
      logic [31:0] e_req_addr;
      bit          e_out_valid;
      logic [31:0] e_out_pc;
      int          e_occ;
   } vec_t;

   pend_t pending[$];
   vec_t  vecs[$];

   bit          s_rst = 1'b1;
   bit          s_redir = 1'b0;
   logic [31:0] s_redir_pc = '0;
   bit          s_req_ready = 1'b1;
   bit          s_out_ready = 1'b1;
   bit          rand_mode = 1'b0;
   int          fixed_lat = 1;
   int          cyc = 0;
   int          last_due = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   function automatic vec_t mk(input bit r, input bit rr, input bit ordy, input bit c,
                               input bit erv, input logic [31:0] ea, input bit eov,
                               input logic [31:0] epc, input int eocc);
      vec_t v;
      v.rst = r; v.req_ready = rr; v.out_ready = ordy; v.chk = c;
      v.e_req_valid = erv; v.e_req_addr = ea; v.e_out_valid = eov;
      v.e_out_pc = epc; v.e_occ = eocc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock: apply staged inputs, present the memory response due this
   // cycle, then record any request handshake into the in-order response queue.
   task automatic cyc_step();
      pend_t p;
      int    lat;
      @(posedge clk);
      #1;
      cyc++;
      rst            = s_rst;
      redirect_valid = s_redir;
      redirect_pc    = s_redir_pc;
      imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : s_req_ready;
      out_ready      = rand_mode ? ($urandom_range(0, 3) != 0) : s_out_ready;
      if (s_rst) begin
         pending.delete();
         last_due = 0;
      end
      if (pending.size() > 0 && pending[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pending[0].addr);
         void'(pending.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      #1;
      if (imem_req_valid && imem_req_ready && !rst) begin
         lat   = rand_mode ? int'($urandom_range(1, 4)) : fixed_lat;
         p.addr = imem_req_addr;
         p.due  = cyc + lat;
         if (p.due <= last_due) p.due = last_due + 1;
         last_due = p.due;
         pending.push_back(p);
      end
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      cyc_step();
      cyc_step();
      s_rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          k;
      int          n_done;
      logic [31:0] exp_pc;

      // Sequence 1: latency 1, consumer always ready.
      vecs.push_back(mk(1,1,1,0, 0,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(1,1,1,1, 0,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(0,1,1,1, 1,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(0,1,1,1, 1,32'h4,  0,32'h0, 0));
      vecs.push_back(mk(0,1,1,1, 1,32'h8,  1,32'h0, 1));
      vecs.push_back(mk(0,1,1,1, 1,32'hC,  1,32'h4, 1));
      vecs.push_back(mk(0,1,1,1, 1,32'h10, 1,32'h8, 1));
      vecs.push_back(mk(0,1,1,1, 1,32'h14, 1,32'hC, 1));
      // Sequence 2: consumer stalled for 12 cycles, then released.
      vecs.push_back(mk(1,1,0,0, 0,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(1,1,0,1, 0,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(0,1,0,1, 1,32'h0,  0,32'h0, 0));
      vecs.push_back(mk(0,1,0,1, 1,32'h4,  0,32'h0, 0));
      vecs.push_back(mk(0,1,0,1, 1,32'h8,  1,32'h0, 1));
      vecs.push_back(mk(0,1,0,1, 1,32'hC,  1,32'h0, 2));
      vecs.push_back(mk(0,1,0,1, 0,32'h0,  1,32'h0, 3));
      for (int i = 0; i < 7; i++)
         vecs.push_back(mk(0,1,0,1, 0,32'h0, 1,32'h0, 4));
      vecs.push_back(mk(0,1,1,1, 0,32'h0,  1,32'h0,  4));
      vecs.push_back(mk(0,1,1,1, 1,32'h10, 1,32'h4,  3));
      vecs.push_back(mk(0,1,1,1, 1,32'h14, 1,32'h8,  2));
      vecs.push_back(mk(0,1,1,1, 1,32'h18, 1,32'hC,  2));
      vecs.push_back(mk(0,1,1,1, 1,32'h1C, 1,32'h10, 2));

      fixed_lat = 1;
      foreach (vecs[i]) begin
         s_rst       = vecs[i].rst;
         s_req_ready = vecs[i].req_ready;
         s_out_ready = vecs[i].out_ready;
         cyc_step();
         chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req_valid));
         if (vecs[i].chk) begin
            if (vecs[i].e_req_valid)
               chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_req_addr);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
            if (vecs[i].e_out_valid) begin
               chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_out_pc);
               chk($sformatf("vec%0d_out_instr", i), out_instr, mem_word(vecs[i].e_out_pc));
            end
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
         end
      end

      // Redirect with two requests in flight, latency 3; low PC bits ignored.
      fixed_lat = 3; s_req_ready = 1'b1; s_out_ready = 1'b1;
      do_reset();
      cyc_step();
      cyc_step();
      s_redir = 1'b1; s_redir_pc = 32'h0000_0103;
      cyc_step();
      s_redir = 1'b0;
      chk("redir_req_blocked", 32'(imem_req_valid), 32'h0);
      cyc_step();
      chk("drain1_req", 32'(imem_req_valid), 32'h0);
      chk("drain1_out_valid", 32'(out_valid), 32'h0);
      cyc_step();
      chk("drain2_req", 32'(imem_req_valid), 32'h0);
      chk("drain2_out_valid", 32'(out_valid), 32'h0);
      cyc_step();
      chk("restart_req", 32'(imem_req_valid), 32'h1);
      chk("restart_addr", imem_req_addr, 32'h100);
      k = 0;
      while (!out_valid && k < 20) begin
         cyc_step();
         k++;
      end
      chk("redir_first_latency", 32'(k), 32'd4);
      chk("redir_first_pc", out_pc, 32'h100);
      chk("redir_first_instr", out_instr, mem_word(32'h100));

      // Redirect coinciding with a pop and a response.
      fixed_lat = 1;
      do_reset();
      cyc_step();
      cyc_step();
      cyc_step();
      s_redir = 1'b1; s_redir_pc = 32'h0000_0200;
      cyc_step();
      s_redir = 1'b0;
      chk("rpr_pop_valid", 32'(out_valid & out_ready), 32'h1);
      chk("rpr_pop_pc", out_pc, 32'h4);
      chk("rpr_rsp_present", 32'(imem_rsp_valid), 32'h1);
      cyc_step();
      chk("rpr_occ_after", 32'(occupancy), 32'h0);
      chk("rpr_out_valid_after", 32'(out_valid), 32'h0);
      chk("rpr_req_valid", 32'(imem_req_valid), 32'h1);
      chk("rpr_req_addr", imem_req_addr, 32'h200);
      cyc_step();
      chk("rpr_out_valid_gap", 32'(out_valid), 32'h0);
      cyc_step();
      chk("rpr_new_valid", 32'(out_valid), 32'h1);
      chk("rpr_new_pc", out_pc, 32'h200);

      // Reset mid-stream with three entries held.
      fixed_lat = 1; s_out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) cyc_step();
      chk("midrst_occ_before", 32'(occupancy), 32'h3);
      s_rst = 1'b1;
      cyc_step();
      chk("midrst_req_in_rst", 32'(imem_req_valid), 32'h0);
      s_rst = 1'b0;
      cyc_step();
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_occ", 32'(occupancy), 32'h0);
      chk("midrst_req_valid", 32'(imem_req_valid), 32'h1);
      chk("midrst_req_addr", imem_req_addr, 32'h0);

      // Random ready, random latency 1-4, occasional redirects.
      s_out_ready = 1'b1;
      do_reset();
      rand_mode = 1'b1;
      exp_pc = 32'h0;
      n_done = 0;
      for (int i = 0; i < 20000 && n_done < 1000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            s_redir    = 1'b1;
            s_redir_pc = $urandom();
         end else begin
            s_redir = 1'b0;
         end
         cyc_step();
         if (out_valid && out_ready) begin
            chk("rand_pc", out_pc, exp_pc);
            chk("rand_instr", out_instr, mem_word(out_pc));
            exp_pc = out_pc + 32'd4;
            n_done++;
         end
         if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      end
      s_redir = 1'b0;
      rand_mode = 1'b0;
      chk("rand_instr_count", 32'(n_done), 32'd1000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
